fifo_fetch_rr: RTL and testbench
================================

Name: fifo_fetch_rr

Overview:
- Multi-channel, parametrised successor to the single-FIFO raw-data fetch FSM.
- Watches NUM_CH upstream FIFOs and picks a non-empty, enabled channel by round-robin.
- Pops one word from the chosen FIFO, captures it into an output register, and presents it downstream with a valid/accepted handshake.
- Tags each word with its source channel; sits between the per-channel raw-data FIFOs and the shared downstream consumer.

Parameters:
- NUM_CH, 4, number of upstream FIFO channels (1..2**CH_W).
- DATA_W, 32, width of each FIFO data word.
- CH_W, 2, width of the channel index; must satisfy NUM_CH <= 2**CH_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- fifo_empty  input  NUM_CH  per-channel FIFO empty flag; bit i = channel i.
- fifo_pop  output  NUM_CH  per-channel pop strobe, one-hot or zero.
- fifo_data  input  NUM_CH*DATA_W  concatenated FIFO read data; channel i occupies bits [i*DATA_W +: DATA_W]. Non-show-ahead: data is valid the cycle after the pop.
- ch_enable  input  NUM_CH  per-channel arbitration enable; 0 excludes the channel from new grants.
- out_data  output  DATA_W  captured word, registered.
- out_ch  output  CH_W  source channel of out_data, registered.
- out_valid  output  1  out_data/out_ch valid.
- out_accepted  input  1  consumer has taken the word this cycle.

Behaviour:
- Reset (async, immediate): state=IDLE, fifo_pop=0, out_valid=0, out_data=0, out_ch=0, rr_last=NUM_CH-1, so channel 0 has first priority.
- Request vector: req = ~fifo_empty & ch_enable.
- Round-robin pick: search starts at rr_last+1 and wraps modulo NUM_CH; the first set req bit wins.
- IDLE:
  - If req != 0: assert fifo_pop[pick] combinationally this cycle, register grant=pick, set rr_last=pick, go to LOAD.
  - Else stay in IDLE with fifo_pop=0.
- LOAD:
  - fifo_pop=0.
  - out_data <= fifo_data[grant]; out_ch <= grant; go to READY.
- READY:
  - out_valid=1; out_data and out_ch held stable.
  - On out_accepted=1 go to IDLE; otherwise stay.
- Latency: fifo not-empty in IDLE to out_valid high is 2 cycles. Throughput (base) is 1 word per 3 cycles.
- Invariants:
  - fifo_pop never asserted outside IDLE (or READY with the option below).
  - At most one fifo_pop bit high in any cycle.
  - No pop issued to a channel whose empty=1 in that cycle.
- Boundary conditions:
  - out_accepted outside READY: ignored.
  - ch_enable deasserted for the granted channel during LOAD/READY: the transaction completes normally; the channel is only excluded from later picks.
  - fifo_empty rising after the pop: no effect on the captured word.
  - Only one requester: it is re-granted every transaction; rr_last wraps correctly.
  - NUM_CH=1: degenerates to single-channel fetch; out_ch is always 0.
  - Reset during LOAD or READY: the captured word is discarded and not re-fetched (data loss is accepted); fifo_pop drops immediately.
  - Undefined state encoding: recover to IDLE on the next clock.

Optional Feature:
- Macro: FIFO_FETCH_RR_PREFETCH_EN.
- Defined: in READY, when out_accepted=1 and req != 0, the pick/pop/rr_last update happens in the same cycle and the next state is LOAD, skipping IDLE. Throughput becomes 1 word per 2 cycles.
- Not defined: READY always returns to IDLE on accept. The READY-state pop logic is absent.
- Round-robin order and all invariants are identical in both builds.

Test Plan:
- Reset then single word: NUM_CH=4, only ch2 non-empty with data 0xA5A5_0002 → fifo_pop=4'b0100 for 1 cycle; 2 cycles later out_valid=1, out_data=0xA5A5_0002, out_ch=2; held until out_accepted.
- Fairness: all 4 channels non-empty, accepted tied high → out_ch sequence 0,1,2,3,0,1; words spaced 3 cycles apart (2 with FIFO_FETCH_RR_PREFETCH_EN).
- Backpressure: out_accepted low for 10 cycles in READY → out_valid stays 1, out_data stable, fifo_pop stays 0 throughout.
- Enable mask: ch_enable=4'b1010, all FIFOs non-empty → only channels 1 and 3 granted, alternating; clearing ch_enable[1] while ch1 is in READY still delivers ch1's word.
- Empty/wrap: rr_last=3, only ch0 non-empty → ch0 granted. FIFO goes empty after the pop → no further pops; block returns to IDLE and idles.
- Async reset mid-READY: assert reset between clock edges → out_valid and fifo_pop drop without waiting for a clock edge. After release, the first grant goes to channel 0.

Source files
------------

// File: rtl/fifo_fetch_rr_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_fetch_rr_if
//  Description : Bundle of the per-channel FIFO read side and the downstream
//                valid/accepted handshake used by fifo_fetch_rr.
//                master = fetch engine, slave = FIFOs plus consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_fetch_rr_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int CH_W   = 2
);
    logic [NUM_CH-1:0]        fifo_empty;
    logic [NUM_CH-1:0]        fifo_pop;
    logic [NUM_CH*DATA_W-1:0] fifo_data;
    logic [NUM_CH-1:0]        ch_enable;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_valid;
    logic                     out_accepted;

    modport master (
        input  fifo_empty, fifo_data, ch_enable, out_accepted,
        output fifo_pop, out_data, out_ch, out_valid
    );

    modport slave (
        output fifo_empty, fifo_data, ch_enable, out_accepted,
        input  fifo_pop, out_data, out_ch, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/fifo_fetch_rr.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_fetch_rr
//  Description : Round-robin fetch from NUM_CH non-show-ahead FIFOs into a
//                registered, channel-tagged output with valid/accepted
//                handshake. Optional back-to-back fetch on accept is enabled
//                by defining FIFO_FETCH_RR_PREFETCH_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_fetch_rr #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int CH_W   = 2
) (
    input  wire             clk,
    input  wire             reset,
    fifo_fetch_rr_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CH_W-1:0]     r_grant;
    logic [CH_W-1:0]     r_rr_last;
    logic [DATA_W-1:0]   r_out_data;
    logic [CH_W-1:0]     r_out_ch;

    logic [NUM_CH-1:0]   w_req;
    logic [CH_W-1:0]     w_pick;
    logic                w_pick_vld;
    logic [NUM_CH-1:0]   w_pop;
    logic                w_take;

    assign w_req = ~bus.fifo_empty & bus.ch_enable;

    // Round-robin search starting just after the last grant; iterating from the
    // farthest offset down lets the nearest requester overwrite earlier hits.
    always_comb begin
        int idx;
        idx        = 0;
        w_pick     = '0;
        w_pick_vld = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = (int'(r_rr_last) + k) % NUM_CH;
            if (w_req[idx]) begin
                w_pick     = CH_W'(idx);
                w_pick_vld = 1'b1;
            end
        end
    end

    // Next-state and pop decode; a pop and grant capture happen together.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = '0;
        w_take      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_pop[w_pick] = 1'b1;
                    w_take        = 1'b1;
                    w_state_nxt   = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_READY;
            end
            S_READY: begin
                if (bus.out_accepted) begin
`ifdef FIFO_FETCH_RR_PREFETCH_EN
                    if (w_pick_vld) begin
                        w_pop[w_pick] = 1'b1;
                        w_take        = 1'b1;
                        w_state_nxt   = S_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
`else
                    w_state_nxt = S_IDLE;
`endif
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; async reset abandons any in-flight word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant/priority tracking and output capture one cycle after the pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant    <= '0;
            r_rr_last  <= CH_W'(NUM_CH - 1);
            r_out_data <= '0;
            r_out_ch   <= '0;
        end else begin
            if (w_take) begin
                r_grant   <= w_pick;
                r_rr_last <= w_pick;
            end
            if (r_state == S_LOAD) begin
                r_out_data <= bus.fifo_data[int'(r_grant)*DATA_W +: DATA_W];
                r_out_ch   <= r_grant;
            end
        end
    end

    // Pop is gated by reset so it drops at once, not on the next edge.
    assign bus.fifo_pop  = reset ? '0 : w_pop;
    assign bus.out_valid = (r_state == S_READY);
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;

endmodule
`default_nettype wire

// File: tb/tb_fifo_fetch_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_fetch_rr
//  Description : Scoreboard bench for fifo_fetch_rr with behavioural
//                non-show-ahead FIFOs on each channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_fetch_rr;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int CH_W   = 2;
`ifdef FIFO_FETCH_RR_PREFETCH_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 3;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fifo_fetch_rr_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) bus_if ();

    fifo_fetch_rr #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    logic [NUM_CH-1:0] femp   = '1;
    logic [NUM_CH-1:0] ch_en  = '1;
    logic              acc    = 1'b0;
    logic [DATA_W-1:0] fdata [NUM_CH] = '{default: '0};
    logic [DATA_W-1:0] fq    [NUM_CH][$];
    logic [DATA_W-1:0] pop_tmp;

    assign bus_if.fifo_empty   = femp;
    assign bus_if.ch_enable    = ch_en;
    assign bus_if.out_accepted = acc;
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_flat
        assign bus_if.fifo_data[gi*DATA_W +: DATA_W] = fdata[gi];
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [CH_W+DATA_W-1:0] sb [$];
    logic [CH_W+DATA_W-1:0] e;
    bit gap_on    = 1'b0;
    bit have_prev = 1'b0;
    int prev_cyc  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Behavioural FIFOs: data appears the cycle after a pop.
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus_if.fifo_pop[i] && fq[i].size() != 0) begin
                pop_tmp  = fq[i].pop_front();
                fdata[i] <= pop_tmp;
            end
            femp[i] <= (fq[i].size() == 0);
        end
    end

    // Monitor: invariants every cycle, scoreboard on each completed handshake.
    always @(negedge clk) begin
        if (!reset) begin
            check("pop_onehot0", 64'($countones(bus_if.fifo_pop) <= 1), 64'd1);
            check("pop_on_empty", 64'(bus_if.fifo_pop & femp), 64'd0);
            if (bus_if.out_valid && acc) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_word: got ch%0d data %h, required no word",
                             bus_if.out_ch, bus_if.out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_ch", 64'(bus_if.out_ch), 64'(e[DATA_W +: CH_W]));
                    check("out_data", 64'(bus_if.out_data), 64'(e[DATA_W-1:0]));
                end
                if (gap_on) begin
                    if (have_prev) check("word_gap", 64'(cyc - prev_cyc), 64'(GAP));
                    prev_cyc  = cyc;
                    have_prev = 1'b1;
                end
            end
            if (!gap_on) have_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int ch, input logic [DATA_W-1:0] d, input bit expect_out);
        fq[ch].push_back(d);
        if (expect_out) sb.push_back({CH_W'(ch), d});
    endtask

    task automatic drain(input int maxc);
        int k = 0;
        while (sb.size() != 0 && k < maxc) begin
            tick();
            k++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        sb.delete();
        tick();
        tick();
    endtask

    task automatic wait_valid(input int maxc);
        int k = 0;
        while (!bus_if.out_valid && k < maxc) begin
            tick();
            k++;
        end
        check("wait_valid", 64'(bus_if.out_valid), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_pop", 64'(bus_if.fifo_pop), 64'd0);
        check("rst_valid", 64'(bus_if.out_valid), 64'd0);
        check("rst_data", 64'(bus_if.out_data), 64'd0);
        check("rst_ch", 64'(bus_if.out_ch), 64'd0);
        reset = 1'b0;
        tick();

        // Single word on ch2, latency and backpressure
        load(2, 32'hA5A5_0002, 1'b1);
        tick();
        check("t1_pop", 64'(bus_if.fifo_pop), 64'b0100);
        check("t1_valid_early", 64'(bus_if.out_valid), 64'd0);
        tick();
        check("t1_pop_off", 64'(bus_if.fifo_pop), 64'd0);
        check("t1_valid_load", 64'(bus_if.out_valid), 64'd0);
        tick();
        check("t1_valid", 64'(bus_if.out_valid), 64'd1);
        check("t1_data", 64'(bus_if.out_data), 64'hA5A5_0002);
        check("t1_ch", 64'(bus_if.out_ch), 64'd2);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 64'(bus_if.out_valid), 64'd1);
            check("bp_data", 64'(bus_if.out_data), 64'hA5A5_0002);
            check("bp_pop", 64'(bus_if.fifo_pop), 64'd0);
        end
        acc = 1'b1;
        drain(20);

        // Fairness from reset: 0,1,2,3,0,1,2,3
        reset = 1'b1;
        tick();
        reset = 1'b0;
        gap_on = 1'b1;
        for (int n = 0; n < 2; n++)
            for (int c = 0; c < NUM_CH; c++)
                load(c, 32'h1000_0000 | DATA_W'(n << 4) | DATA_W'(c), 1'b1);
        drain(60);
        gap_on = 1'b0;

        // Enable mask 1010: ch1 and ch3 alternate; ch0/ch2 words wait
        ch_en = 4'b1010;
        load(0, 32'hE000_0000, 1'b0);
        load(2, 32'hE000_0002, 1'b0);
        load(1, 32'hB100_0001, 1'b1);
        load(3, 32'hB300_0003, 1'b1);
        load(1, 32'hB100_0011, 1'b1);
        load(3, 32'hB300_0013, 1'b1);
        drain(40);

        // Clearing ch1 enable while its word sits in READY
        acc = 1'b0;
        load(1, 32'hC1C1_0001, 1'b1);
        wait_valid(10);
        ch_en = 4'b1000;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("en_hold_valid", 64'(bus_if.out_valid), 64'd1);
            check("en_hold_ch", 64'(bus_if.out_ch), 64'd1);
        end
        acc = 1'b1;
        drain(10);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mask_idle_pop", 64'(bus_if.fifo_pop), 64'd0);
        end
        // Re-enable: rr_last=1 so ch2 then ch0
        sb.push_back({CH_W'(2), 32'hE000_0002});
        sb.push_back({CH_W'(0), 32'hE000_0000});
        ch_en = 4'b1111;
        drain(20);

        // Wrap: rr_last=3 then lone requester ch0 granted twice, then idle
        load(3, 32'h3333_0003, 1'b1);
        drain(20);
        load(0, 32'h0000_00A0, 1'b1);
        load(0, 32'h0000_00A1, 1'b1);
        drain(20);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_pop", 64'(bus_if.fifo_pop), 64'd0);
            check("idle_valid", 64'(bus_if.out_valid), 64'd0);
        end

        // Async reset while ch1 word waits in READY; ch3 is pending
        acc = 1'b0;
        load(1, 32'hDEAD_0001, 1'b0);
        load(3, 32'h3333_1003, 1'b0);
        wait_valid(10);
        check("ar_ch_before", 64'(bus_if.out_ch), 64'd1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", 64'(bus_if.out_valid), 64'd0);
        check("ar_pop", 64'(bus_if.fifo_pop), 64'd0);
        check("ar_data", 64'(bus_if.out_data), 64'd0);
        tick();
        load(0, 32'h0000_0C00, 1'b1);
        sb.push_back({CH_W'(3), 32'h3333_1003});
        tick();
        reset = 1'b0;
        acc = 1'b1;
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
